// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
//   Carries decoded ID-stage controls through the ID/EX, EX/MEM and MEM/WB
//   stage registers, detects load-use hazards (stall + bubble) and taken
//   branches (flush), produces EX-stage forwarding selects, and keeps a
//   saturating count of inserted load-use bubbles.
// Ports
//   clk, reset                : rising-edge clock, synchronous active-high reset
//   id_*                      : decoded controls and register fields of the ID instruction
//   branch_taken              : branch/jump resolved taken in MEM
//   ex_*, mem_*, wb_*         : registered stage controls / register fields
//   pc_write, ifid_write      : 0 = hold PC / IF/ID (combinational)
//   ifid_flush                : 1 = zero IF/ID (combinational)
//   fwd_a, fwd_b              : 00 regfile, 10 from MEM, 01 from WB (combinational)
//   bubble_cnt                : load-use bubbles inserted, saturating
module ctrl_pipe_hazard #(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_MemToReg,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_Branch,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               branch_taken,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [RA_W-1:0]    ex_rs,
  output logic [RA_W-1:0]    ex_rt,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_Branch,
  output logic [RA_W-1:0]    mem_write_reg,
  output logic               wb_RegWrite,
  output logic               wb_MemToReg,
  output logic [RA_W-1:0]    wb_write_reg,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               RegDst;
    logic               ALUSrc;
    logic               MemToReg;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               Branch;
    logic [ALUOP_W-1:0] ALUOp;
    logic [RA_W-1:0]    rs;
    logic [RA_W-1:0]    rt;
    logic [RA_W-1:0]    rd;
  } ex_t;

  typedef struct packed {
    logic            MemToReg;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            Branch;
    logic [RA_W-1:0] wr;
  } mem_t;

  typedef struct packed {
    logic            MemToReg;
    logic            RegWrite;
    logic [RA_W-1:0] wr;
  } wb_t;

  // The all-zero value of each stage struct is the NOP encoding.
  ex_t              r_ex;
  mem_t             r_mem;
  wb_t              r_wb;
  logic [CNT_W-1:0] r_bubble_cnt;

  ex_t              w_id;
  mem_t             w_ex_to_mem;
  wb_t              w_mem_to_wb;
  logic             w_stall;
  logic             w_flush;

  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            mem_rw,
    input logic [RA_W-1:0] mem_wr,
    input logic            wb_rw,
    input logic [RA_W-1:0] wb_wr
  );
    if (mem_rw && (mem_wr != '0) && (mem_wr == src)) return 2'b10;
    else if (wb_rw && (wb_wr != '0) && (wb_wr == src)) return 2'b01;
    else return 2'b00;
  endfunction

  always_comb begin
    w_id          = '0;
    w_id.RegDst   = id_RegDst;
    w_id.ALUSrc   = id_ALUSrc;
    w_id.MemToReg = id_MemToReg;
    w_id.RegWrite = id_RegWrite;
    w_id.MemRead  = id_MemRead;
    w_id.MemWrite = id_MemWrite;
    w_id.Branch   = id_Branch;
    w_id.ALUOp    = id_ALUOp;
    w_id.rs       = id_rs;
    w_id.rt       = id_rt;
    w_id.rd       = id_rd;

    w_ex_to_mem          = '0;
    w_ex_to_mem.MemToReg = r_ex.MemToReg;
    w_ex_to_mem.RegWrite = r_ex.RegWrite;
    w_ex_to_mem.MemRead  = r_ex.MemRead;
    w_ex_to_mem.MemWrite = r_ex.MemWrite;
    w_ex_to_mem.Branch   = r_ex.Branch;
    w_ex_to_mem.wr       = r_ex.RegDst ? r_ex.rd : r_ex.rt;

    w_mem_to_wb          = '0;
    w_mem_to_wb.MemToReg = r_mem.MemToReg;
    w_mem_to_wb.RegWrite = r_mem.RegWrite;
    w_mem_to_wb.wr       = r_mem.wr;
  end

  // Flush has priority: a load-use stall is suppressed when a branch is taken.
  assign w_flush = branch_taken;
  assign w_stall = r_ex.MemRead && (r_ex.rt != '0) &&
                   ((r_ex.rt == id_rs) || (r_ex.rt == id_rt)) && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_wb <= w_mem_to_wb;
      if (w_flush) begin
        r_ex  <= '0;
        r_mem <= '0;
      end else if (w_stall) begin
        r_ex  <= '0;
        r_mem <= w_ex_to_mem;
        if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end else begin
        r_ex  <= w_id;
        r_mem <= w_ex_to_mem;
      end
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (!reset) begin
      pc_write   = !w_stall;
      ifid_write = !w_stall;
      ifid_flush = w_flush;
      fwd_a      = fwd_sel(r_ex.rs, r_mem.RegWrite, r_mem.wr, r_wb.RegWrite, r_wb.wr);
      fwd_b      = fwd_sel(r_ex.rt, r_mem.RegWrite, r_mem.wr, r_wb.RegWrite, r_wb.wr);
    end
  end

  assign ex_RegDst     = r_ex.RegDst;
  assign ex_ALUSrc     = r_ex.ALUSrc;
  assign ex_ALUOp      = r_ex.ALUOp;
  assign ex_rs         = r_ex.rs;
  assign ex_rt         = r_ex.rt;
  assign mem_MemRead   = r_mem.MemRead;
  assign mem_MemWrite  = r_mem.MemWrite;
  assign mem_Branch    = r_mem.Branch;
  assign mem_write_reg = r_mem.wr;
  assign wb_RegWrite   = r_wb.RegWrite;
  assign wb_MemToReg   = r_wb.MemToReg;
  assign wb_write_reg  = r_wb.wr;
  assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
module tb_ctrl_pipe_hazard;

  localparam int unsigned RA_W    = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned CNT_W   = 2;  // small so saturation is reachable

  logic               clk = 1'b0;
  logic               reset;
  logic               id_RegDst, id_ALUSrc, id_MemToReg, id_RegWrite;
  logic               id_MemRead, id_MemWrite, id_Branch;
  logic [ALUOP_W-1:0] id_ALUOp;
  logic [RA_W-1:0]    id_rs, id_rt, id_rd;
  logic               branch_taken;
  logic               ex_RegDst, ex_ALUSrc;
  logic [ALUOP_W-1:0] ex_ALUOp;
  logic [RA_W-1:0]    ex_rs, ex_rt;
  logic               mem_MemRead, mem_MemWrite, mem_Branch;
  logic [RA_W-1:0]    mem_write_reg;
  logic               wb_RegWrite, wb_MemToReg;
  logic [RA_W-1:0]    wb_write_reg;
  logic               pc_write, ifid_write, ifid_flush;
  logic [1:0]         fwd_a, fwd_b;
  logic [CNT_W-1:0]   bubble_cnt;

  ctrl_pipe_hazard #(.RA_W(RA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemToReg(id_MemToReg),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .branch_taken(branch_taken),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch),
    .mem_write_reg(mem_write_reg),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_write_reg(wb_write_reg),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int unsigned {
    S_EX_REGDST, S_EX_ALUSRC, S_EX_ALUOP, S_EX_RS, S_EX_RT,
    S_MEM_MEMREAD, S_MEM_MEMWRITE, S_MEM_BRANCH, S_MEM_WR,
    S_WB_REGWRITE, S_WB_MEMTOREG, S_WB_WR,
    S_PC_WRITE, S_IFID_WRITE, S_IFID_FLUSH, S_FWD_A, S_FWD_B, S_BUBBLE
  } sig_e;

  typedef struct {
    sig_e        sig;
    int unsigned due;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] obs;

  // Expected value of signal s, k cycles after the current drive point.
  function automatic void expect_at(sig_e s, int unsigned k, logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.due = cyc + k;
    e.val = v;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_EX_REGDST:    return 32'(ex_RegDst);
      S_EX_ALUSRC:    return 32'(ex_ALUSrc);
      S_EX_ALUOP:     return 32'(ex_ALUOp);
      S_EX_RS:        return 32'(ex_rs);
      S_EX_RT:        return 32'(ex_rt);
      S_MEM_MEMREAD:  return 32'(mem_MemRead);
      S_MEM_MEMWRITE: return 32'(mem_MemWrite);
      S_MEM_BRANCH:   return 32'(mem_Branch);
      S_MEM_WR:       return 32'(mem_write_reg);
      S_WB_REGWRITE:  return 32'(wb_RegWrite);
      S_WB_MEMTOREG:  return 32'(wb_MemToReg);
      S_WB_WR:        return 32'(wb_write_reg);
      S_PC_WRITE:     return 32'(pc_write);
      S_IFID_WRITE:   return 32'(ifid_write);
      S_IFID_FLUSH:   return 32'(ifid_flush);
      S_FWD_A:        return 32'(fwd_a);
      S_FWD_B:        return 32'(fwd_b);
      S_BUBBLE:       return 32'(bubble_cnt);
      default:        return '0;
    endcase
  endfunction

  task automatic set_idle();
    reset = 1'b0; branch_taken = 1'b0;
    id_RegDst = 1'b0; id_ALUSrc = 1'b0; id_MemToReg = 1'b0; id_RegWrite = 1'b0;
    id_MemRead = 1'b0; id_MemWrite = 1'b0; id_Branch = 1'b0;
    id_ALUOp = '0; id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic set_load(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt);
    id_MemRead = 1'b1; id_RegWrite = 1'b1; id_MemToReg = 1'b1; id_ALUSrc = 1'b1;
    id_rs = rs; id_rt = rt;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      set_idle();
      case (s)
        0: begin
          reset = 1'b1; id_RegWrite = 1'b1; id_RegDst = 1'b1; id_rd = 5'd4;
          expect_at(S_PC_WRITE, 0, 1); expect_at(S_IFID_WRITE, 0, 1);
          expect_at(S_IFID_FLUSH, 0, 0); expect_at(S_FWD_A, 0, 0);
        end
        1: begin
          reset = 1'b1; id_RegWrite = 1'b1; id_RegDst = 1'b1; id_rd = 5'd4;
          branch_taken = 1'b1;
          expect_at(S_IFID_FLUSH, 0, 0); expect_at(S_PC_WRITE, 0, 1);
          expect_at(S_EX_REGDST, 0, 0); expect_at(S_EX_ALUOP, 0, 0);
          expect_at(S_EX_RS, 0, 0); expect_at(S_EX_RT, 0, 0);
          expect_at(S_MEM_WR, 0, 0); expect_at(S_MEM_MEMREAD, 0, 0);
          expect_at(S_WB_REGWRITE, 0, 0); expect_at(S_WB_WR, 0, 0);
          expect_at(S_BUBBLE, 0, 0); expect_at(S_FWD_B, 0, 0);
        end
        default: begin
          expect_at(S_EX_REGDST, 0, 0); expect_at(S_WB_REGWRITE, 0, 0);
          expect_at(S_IFID_FLUSH, 0, 0);
        end
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL reset/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    for (int s = 0; s < 6; s++) begin
      set_idle();
      case (s)
        0: begin
          id_RegDst = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b10;
          id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
          expect_at(S_PC_WRITE, 0, 1);
          expect_at(S_EX_ALUOP, 1, 2); expect_at(S_EX_REGDST, 1, 1);
          expect_at(S_EX_RS, 1, 1); expect_at(S_EX_RT, 1, 2);
          expect_at(S_MEM_WR, 2, 3);
          expect_at(S_WB_REGWRITE, 3, 1); expect_at(S_WB_WR, 3, 3);
        end
        1: begin
          id_ALUSrc = 1'b1; id_RegWrite = 1'b1; id_rs = 5'd2; id_rt = 5'd6; id_rd = 5'd9;
          expect_at(S_EX_ALUSRC, 1, 1); expect_at(S_EX_REGDST, 1, 0);
          expect_at(S_MEM_WR, 2, 6); expect_at(S_WB_WR, 3, 6);
        end
        2: begin
          id_Branch = 1'b1; id_ALUOp = 2'b01;
          expect_at(S_EX_ALUOP, 1, 1); expect_at(S_MEM_BRANCH, 2, 1);
          expect_at(S_WB_REGWRITE, 3, 0);
        end
        3: begin
          id_MemWrite = 1'b1; id_ALUSrc = 1'b1; id_rt = 5'd4;
          expect_at(S_MEM_MEMWRITE, 2, 1); expect_at(S_MEM_BRANCH, 2, 0);
        end
        default: ;
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL rtype/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Bubble count enters at 0.
  task automatic test_load_use();
    for (int s = 0; s < 5; s++) begin
      set_idle();
      case (s)
        0: begin
          set_load(5'd1, 5'd5);
          expect_at(S_PC_WRITE, 0, 1);
        end
        1, 2: begin
          // Dependent R-type held in IF/ID while the bubble is inserted.
          id_RegDst = 1'b1; id_RegWrite = 1'b1; id_rs = 5'd5; id_rt = 5'd8; id_rd = 5'd10;
          if (s == 1) begin
            expect_at(S_PC_WRITE, 0, 0); expect_at(S_IFID_WRITE, 0, 0);
            expect_at(S_IFID_FLUSH, 0, 0); expect_at(S_BUBBLE, 0, 0);
          end else begin
            expect_at(S_PC_WRITE, 0, 1); expect_at(S_IFID_WRITE, 0, 1);
            expect_at(S_EX_REGDST, 0, 0); expect_at(S_EX_ALUSRC, 0, 0);
            expect_at(S_EX_ALUOP, 0, 0); expect_at(S_EX_RS, 0, 0); expect_at(S_EX_RT, 0, 0);
            expect_at(S_BUBBLE, 0, 1);
            expect_at(S_MEM_MEMREAD, 0, 1); expect_at(S_MEM_WR, 0, 5);
            expect_at(S_EX_RS, 1, 5); expect_at(S_EX_RT, 1, 8);
            expect_at(S_FWD_A, 1, 1); expect_at(S_FWD_B, 1, 0);
            expect_at(S_WB_MEMTOREG, 1, 1); expect_at(S_WB_WR, 1, 5);
          end
        end
        3: expect_at(S_MEM_WR, 1, 10);
        default: expect_at(S_BUBBLE, 0, 1);
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL load_use/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Bubble count enters at 1.
  task automatic test_load_use_r0();
    for (int s = 0; s < 4; s++) begin
      set_idle();
      case (s)
        0: set_load(5'd3, 5'd0);
        1: begin
          id_RegDst = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b01; id_rd = 5'd2;
          expect_at(S_PC_WRITE, 0, 1); expect_at(S_IFID_WRITE, 0, 1);
          expect_at(S_EX_ALUOP, 1, 1); expect_at(S_MEM_MEMREAD, 1, 1);
          expect_at(S_BUBBLE, 1, 1);
        end
        default: ;
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL load_use_r0/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    for (int s = 0; s < 9; s++) begin
      set_idle();
      case (s)
        0, 1: begin id_RegWrite = 1'b1; id_RegDst = 1'b1; id_rd = 5'd7; end
        2: begin
          id_rs = 5'd7; id_rt = 5'd3;
          expect_at(S_EX_RS, 1, 7); expect_at(S_FWD_A, 1, 2); expect_at(S_FWD_B, 1, 0);
        end
        3: begin
          id_rs = 5'd7; id_rt = 5'd7;
          expect_at(S_FWD_A, 1, 1); expect_at(S_FWD_B, 1, 1);
        end
        4: begin
          id_RegWrite = 1'b1; id_rs = 5'd7; id_rt = 5'd7;
          expect_at(S_FWD_A, 1, 0); expect_at(S_FWD_B, 1, 0);
        end
        5: begin
          id_rs = 5'd2; id_rt = 5'd7;
          expect_at(S_FWD_A, 1, 0); expect_at(S_FWD_B, 1, 2);
        end
        6: begin id_RegWrite = 1'b1; id_RegDst = 1'b1; id_rd = 5'd0; end
        7: begin expect_at(S_FWD_A, 1, 0); expect_at(S_FWD_B, 1, 0); end
        default: ;
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL forwarding/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Bubble count enters at 1.
  task automatic test_flush();
    for (int s = 0; s < 4; s++) begin
      set_idle();
      case (s)
        0: set_load(5'd1, 5'd6);
        1: begin
          id_RegWrite = 1'b1; id_RegDst = 1'b1; id_rs = 5'd6; id_rd = 5'd11;
          branch_taken = 1'b1;
          expect_at(S_IFID_FLUSH, 0, 1); expect_at(S_PC_WRITE, 0, 1);
          expect_at(S_IFID_WRITE, 0, 1);
        end
        2: begin
          expect_at(S_EX_ALUSRC, 0, 0); expect_at(S_EX_RS, 0, 0); expect_at(S_EX_RT, 0, 0);
          expect_at(S_EX_REGDST, 0, 0); expect_at(S_MEM_MEMREAD, 0, 0);
          expect_at(S_MEM_WR, 0, 0); expect_at(S_BUBBLE, 0, 1);
          expect_at(S_IFID_FLUSH, 0, 0);
          expect_at(S_WB_REGWRITE, 1, 0); expect_at(S_WB_MEMTOREG, 1, 0);
        end
        default: ;
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL flush/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Bubble count enters at 1 and leaves at 3.
  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      set_idle();
      case (s)
        0: set_load(5'd2, 5'd4);
        1, 2: begin
          set_load(5'd4, 5'd9);
          if (s == 1) expect_at(S_PC_WRITE, 0, 0);
          else begin
            expect_at(S_PC_WRITE, 0, 1); expect_at(S_BUBBLE, 0, 2); expect_at(S_MEM_WR, 0, 4);
          end
        end
        3, 4: begin
          id_RegWrite = 1'b1; id_RegDst = 1'b1; id_rs = 5'd1; id_rt = 5'd9; id_rd = 5'd12;
          if (s == 3) begin
            expect_at(S_PC_WRITE, 0, 0); expect_at(S_IFID_WRITE, 0, 0); expect_at(S_EX_RT, 0, 9);
          end else begin
            expect_at(S_PC_WRITE, 0, 1); expect_at(S_BUBBLE, 0, 3);
            expect_at(S_MEM_WR, 0, 9); expect_at(S_EX_RT, 0, 0);
          end
        end
        default: begin
          expect_at(S_EX_RT, 0, 9); expect_at(S_FWD_B, 0, 1); expect_at(S_FWD_A, 0, 0);
        end
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL back_to_back/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Bubble count enters at its maximum (3) and must stay there.
  task automatic test_saturate();
    for (int s = 0; s < 3; s++) begin
      set_idle();
      case (s)
        0: set_load(5'd1, 5'd5);
        1: begin id_rs = 5'd5; expect_at(S_PC_WRITE, 0, 0); end
        default: expect_at(S_BUBBLE, 0, 3);
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL saturate/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int s = 0; s < 4; s++) begin
      set_idle();
      case (s)
        0: set_load(5'd1, 5'd3);
        1: begin
          id_rs = 5'd3; reset = 1'b1;
          expect_at(S_PC_WRITE, 0, 1); expect_at(S_IFID_WRITE, 0, 1);
        end
        2: begin
          id_rs = 5'd3;
          expect_at(S_EX_RT, 0, 0); expect_at(S_MEM_MEMREAD, 0, 0); expect_at(S_MEM_WR, 0, 0);
          expect_at(S_BUBBLE, 0, 0); expect_at(S_PC_WRITE, 0, 1);
        end
        default: expect_at(S_WB_REGWRITE, 0, 0);
      endcase
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          obs = observe(sb[i].sig);
          checks++;
          if (obs !== sb[i].val) begin
            failures++;
            $display("FAIL reset_mid_stall/%s cyc=%0d got=%0h exp=%0h", sb[i].sig.name(), cyc, obs, sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    set_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_load_use();
    test_load_use_r0();
    test_forwarding();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
